// File: rtl/i2c_bus_arb.sv
// Two-port round-robin arbiter in front of a single I2C master core.
// Latches one-cycle requests per port, issues them one at a time and returns done/err/read data.
module i2c_bus_arb #(
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        wr0,
    input  logic        wr1,
    input  logic        rd0,
    input  logic        rd1,
    input  logic [6:0]  adr0,
    input  logic [6:0]  adr1,
    input  logic [31:0] wr_data0,
    input  logic [31:0] wr_data1,
    input  logic [2:0]  wr_bytes0,
    input  logic [2:0]  wr_bytes1,
    input  logic [2:0]  rd_bytes0,
    input  logic [2:0]  rd_bytes1,
    output logic        busy0,
    output logic        busy1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    output logic        wr,
    output logic        rd,
    output logic [6:0]  adr,
    output logic [31:0] wr_data,
    output logic [2:0]  wr_bytes,
    output logic [2:0]  rd_bytes,
    input  logic        busy,
    input  logic [31:0] rd_data
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    // WAIT_HI spans BUSY_TIMEOUT-1 cycles so err lands BUSY_TIMEOUT cycles after ISSUE
    localparam logic [CW-1:0] TMO_LOAD = CW'(BUSY_TIMEOUT - 2);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       pend_q, pend_d, pop_q, pop_d;
    logic [1:0][6:0]  padr_q, padr_d;
    logic [1:0][31:0] pdat_q, pdat_d;
    logic [1:0][2:0]  pwb_q, pwb_d, prb_q, prb_d;
    logic             gnt_q, gnt_d, last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_q, wr_d, rd_q, rd_d;
    logic [6:0]       adr_q, adr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [2:0]       wb_q, wb_d, rb_q, rb_d;
    logic [1:0]       done_q, done_d, err_q, err_d;
    logic [1:0][31:0] rdd_q, rdd_d;

    logic [1:0]       s_wr, s_req, s_ok;
    logic [1:0][6:0]  s_adr;
    logic [1:0][31:0] s_dat;
    logic [1:0][2:0]  s_wb, s_rb;

    function automatic logic cnt_ok(input logic [2:0] n);
        return (n != 3'd0) && (n <= 3'd4);
    endfunction

    assign s_wr  = {wr1, wr0};
    assign s_req = ({wr1, wr0} | {rd1, rd0}) & ~pend_q;
    assign s_adr = {adr1, adr0};
    assign s_dat = {wr_data1, wr_data0};
    assign s_wb  = {wr_bytes1, wr_bytes0};
    assign s_rb  = {rd_bytes1, rd_bytes0};
    assign s_ok  = {cnt_ok(wr1 ? wr_bytes1 : rd_bytes1), cnt_ok(wr0 ? wr_bytes0 : rd_bytes0)};

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pop_d   = pop_q;
        padr_d  = padr_q;
        pdat_d  = pdat_q;
        pwb_d   = pwb_q;
        prb_d   = prb_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        wb_d    = wb_q;
        rb_d    = rb_q;
        done_d  = '0;
        err_d   = '0;
        rdd_d   = rdd_q;

        for (int p = 0; p < 2; p++) begin
            if (s_req[p] && s_ok[p]) begin
                pend_d[p] = 1'b1;
                pop_d[p]  = ~s_wr[p];
                padr_d[p] = s_adr[p];
                pdat_d[p] = s_dat[p];
                pwb_d[p]  = s_wb[p];
                prb_d[p]  = s_rb[p];
            end else if (s_req[p]) begin
                done_d[p] = 1'b1;
                err_d[p]  = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    gnt_d   = (&pend_q) ? ~last_q : pend_q[1];
                    last_d  = gnt_d;
                    wr_d    = ~pop_q[gnt_d];
                    rd_d    = pop_q[gnt_d];
                    adr_d   = padr_q[gnt_d];
                    wdat_d  = pdat_q[gnt_d];
                    wb_d    = pwb_q[gnt_d];
                    rb_d    = prb_q[gnt_d];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = TMO_LOAD;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q == '0) begin
                    state_d       = S_DONE;
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    state_d       = S_DONE;
                    done_d[gnt_q] = 1'b1;
                    if (pop_q[gnt_q]) rdd_d[gnt_q] = rd_data;
                end
            end
            S_DONE: begin
                pend_d[gnt_q] = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            pop_q   <= '0;
            padr_q  <= '0;
            pdat_q  <= '0;
            pwb_q   <= '0;
            prb_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            adr_q   <= 7'h27;
            wdat_q  <= '0;
            wb_q    <= '0;
            rb_q    <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdd_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pop_q   <= pop_d;
            padr_q  <= padr_d;
            pdat_q  <= pdat_d;
            pwb_q   <= pwb_d;
            prb_q   <= prb_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdd_q   <= rdd_d;
        end
    end

    assign busy0    = pend_q[0];
    assign busy1    = pend_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign err0     = err_q[0];
    assign err1     = err_q[1];
    assign rd_data0 = rdd_q[0];
    assign rd_data1 = rdd_q[1];
    assign wr       = wr_q;
    assign rd       = rd_q;
    assign adr      = adr_q;
    assign wr_data  = wdat_q;
    assign wr_bytes = wb_q;
    assign rd_bytes = rb_q;
endmodule

// File: tb/tb_i2c_bus_arb.sv
// Directed bench for i2c_bus_arb: arbitration order, timing, timeout, rejection and reset.
module tb_i2c_bus_arb;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rstb;
    logic        wr0, wr1, rd0, rd1;
    logic [6:0]  adr0, adr1;
    logic [31:0] wr_data0, wr_data1;
    logic [2:0]  wr_bytes0, wr_bytes1, rd_bytes0, rd_bytes1;
    logic        busy0, busy1, done0, done1, err0, err1;
    logic [31:0] rd_data0, rd_data1;
    logic        wr, rd;
    logic [6:0]  adr;
    logic [31:0] wr_data;
    logic [2:0]  wr_bytes, rd_bytes;
    logic        busy;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    i2c_bus_arb #(.BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rstb(rstb),
        .wr0(wr0), .wr1(wr1), .rd0(rd0), .rd1(rd1),
        .adr0(adr0), .adr1(adr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_bytes0(wr_bytes0), .wr_bytes1(wr_bytes1),
        .rd_bytes0(rd_bytes0), .rd_bytes1(rd_bytes1),
        .busy0(busy0), .busy1(busy1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr(wr), .rd(rd), .adr(adr), .wr_data(wr_data),
        .wr_bytes(wr_bytes), .rd_bytes(rd_bytes),
        .busy(busy), .rd_data(rd_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic no_strobe;
        wr0 = 0; wr1 = 0; rd0 = 0; rd1 = 0;
    endtask

    // Called in the ISSUE cycle; returns in the DONE cycle. hold >= 2.
    task automatic serve(input int hold, input logic [31:0] rv);
        busy = 1'b1;
        repeat (hold) tick;
        busy = 1'b0;
        rd_data = rv;
        tick;
    endtask

    task automatic do_reset;
        rstb = 1'b0;
        tick;
        tick;
        rstb = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        no_strobe();
        adr0 = 7'h00; adr1 = 7'h00; wr_data0 = 0; wr_data1 = 0;
        wr_bytes0 = 0; wr_bytes1 = 0; rd_bytes0 = 0; rd_bytes1 = 0;
        busy = 0; rd_data = 0;
        rstb = 1'b0;
        tick;
        tick;
        chk("rst_wr", wr, 0);
        chk("rst_rd", rd, 0);
        chk("rst_adr", adr, 7'h27);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_bytes", {wr_bytes, rd_bytes}, 0);
        chk("rst_flags", {busy0, busy1, done0, done1, err0, err1}, 0);
        chk("rst_rd_data", {rd_data0 | rd_data1}, 0);
        rstb = 1'b1;

        // Port 0 write
        wr0 = 1; adr0 = 7'h27; wr_data0 = 32'h3C000000; wr_bytes0 = 3'd1; rd_bytes0 = 3'd0;
        tick; no_strobe();
        chk("t1_busy0", busy0, 1);
        chk("t1_wr_early", wr, 0);
        tick;
        chk("t1_wr", wr, 1);
        chk("t1_rd", rd, 0);
        chk("t1_adr", adr, 7'h27);
        chk("t1_wr_data", wr_data, 32'h3C000000);
        chk("t1_wr_bytes", wr_bytes, 3'd1);
        serve(20, 32'hDEADBEEF);
        chk("t1_done0", done0, 1);
        chk("t1_err0", err0, 0);
        chk("t1_busy0_at_done", busy0, 1);
        chk("t1_rd_data0_kept", rd_data0, 0);
        chk("t1_adr_hold", adr, 7'h27);
        tick;
        chk("t1_done0_end", done0, 0);
        chk("t1_busy0_end", busy0, 0);

        // Port 1 read
        rd1 = 1; adr1 = 7'h48; rd_bytes1 = 3'd2; wr_bytes1 = 3'd0;
        tick; no_strobe();
        chk("t2_busy1", busy1, 1);
        tick;
        chk("t2_rd", rd, 1);
        chk("t2_wr", wr, 0);
        chk("t2_adr", adr, 7'h48);
        chk("t2_rd_bytes", rd_bytes, 3'd2);
        serve(5, 32'h1A800000);
        chk("t2_done1", done1, 1);
        chk("t2_err1", err1, 0);
        chk("t2_rd_data1", rd_data1, 32'h1A800000);
        chk("t2_rd_data0", rd_data0, 0);
        tick;
        chk("t2_busy1_end", busy1, 0);

        // Contention after reset: port 0 first, then port 1
        do_reset();
        wr0 = 1; adr0 = 7'h20; wr_data0 = 32'h11223344; wr_bytes0 = 3'd4;
        rd1 = 1; adr1 = 7'h48; rd_bytes1 = 3'd1;
        tick; no_strobe();
        chk("t3_both_busy", {busy0, busy1}, 2'b11);
        tick;
        chk("t3_first_wr", wr, 1);
        chk("t3_first_adr", adr, 7'h20);
        serve(3, 32'h0);
        chk("t3_done0", {done0, done1}, 2'b10);
        tick;
        chk("t3_gap_rd", rd, 0);
        chk("t3_gap_busy", {busy0, busy1}, 2'b01);
        tick;
        chk("t3_second_rd", rd, 1);
        chk("t3_second_adr", adr, 7'h48);
        chk("t3_second_rd_bytes", rd_bytes, 3'd1);
        serve(2, 32'hAB000000);
        chk("t3_done1", {done0, done1}, 2'b01);
        chk("t3_rd_data1", rd_data1, 32'hAB000000);
        tick;
        // Lone port 0 transaction so port 0 was served last
        wr0 = 1;
        tick; no_strobe();
        tick;
        chk("t3_lone_wr", wr, 1);
        serve(2, 32'h0);
        chk("t3_lone_done0", done0, 1);
        tick;
        wr0 = 1; rd1 = 1;
        tick; no_strobe();
        tick;
        chk("t3_rr_first_rd", rd, 1);
        chk("t3_rr_first_adr", adr, 7'h48);
        serve(2, 32'h0000CAFE);
        chk("t3_rr_done1", {done0, done1}, 2'b01);
        tick;
        tick;
        chk("t3_rr_second_wr", wr, 1);
        chk("t3_rr_second_adr", adr, 7'h20);
        serve(2, 32'h0);
        chk("t3_rr_done0", {done0, done1}, 2'b10);
        tick;

        // Timeout: master never raises busy
        wr0 = 1; adr0 = 7'h27; wr_bytes0 = 3'd1;
        tick; no_strobe();
        tick;
        chk("t4_wr", wr, 1);
        seen = 0;
        repeat (TMO - 1) begin
            tick;
            seen = seen | done0 | err0;
        end
        chk("t4_no_early_done", seen, 0);
        tick;
        chk("t4_done_err0", {done0, err0}, 2'b11);
        tick;
        chk("t4_busy0_end", busy0, 0);
        rd1 = 1; adr1 = 7'h4A; rd_bytes1 = 3'd3;
        tick; no_strobe();
        tick;
        chk("t4_p1_rd", rd, 1);
        chk("t4_p1_adr", adr, 7'h4A);
        serve(2, 32'h55667788);
        chk("t4_p1_done_err", {done1, err1}, 2'b10);
        chk("t4_p1_rd_data1", rd_data1, 32'h55667788);
        tick;

        // Rejections
        wr0 = 1; wr_bytes0 = 3'd0;
        tick; no_strobe();
        chk("t5_rej0", {done0, err0, busy0}, 3'b110);
        rd1 = 1; rd_bytes1 = 3'd5;
        tick; no_strobe();
        chk("t5_rej1", {done1, err1, busy1}, 3'b110);
        chk("t5_rej0_gone", done0, 0);
        tick;
        chk("t5_no_master", {wr, rd, done1}, 0);

        // wr0+rd0 together: write wins; second strobe while busy0 ignored
        wr0 = 1; rd0 = 1; adr0 = 7'h31; wr_data0 = 32'hA5000000; wr_bytes0 = 3'd2; rd_bytes0 = 3'd0;
        tick; no_strobe();
        chk("t5_both_busy0", {busy0, done0}, 2'b10);
        wr0 = 1; wr_bytes0 = 3'd1; adr0 = 7'h11;
        tick; no_strobe();
        chk("t5_both_wr", {wr, rd}, 2'b10);
        chk("t5_both_wr_bytes", wr_bytes, 3'd2);
        chk("t5_both_adr", adr, 7'h31);
        serve(3, 32'h0);
        chk("t5_single_done0", {done0, err0}, 2'b10);
        seen = 0;
        repeat (5) begin
            tick;
            seen = seen | done0 | wr | rd | busy0;
        end
        chk("t5_ignored_strobe", seen, 0);

        // Reset during WAIT_LO
        wr0 = 1; adr0 = 7'h22; wr_data0 = 32'h77000000; wr_bytes0 = 3'd1;
        tick; no_strobe();
        tick;
        chk("t6_wr", wr, 1);
        busy = 1;
        tick;
        tick;
        rstb = 1'b0;
        #1;
        chk("t6_rst_flags", {busy0, busy1, done0, done1, err0, err1}, 0);
        chk("t6_rst_adr", adr, 7'h27);
        chk("t6_rst_wr_data", wr_data, 0);
        chk("t6_rst_rd_data1", rd_data1, 0);
        tick;
        tick;
        rstb = 1'b1;
        busy = 0;
        seen = 0;
        repeat (4) begin
            tick;
            seen = seen | done0 | done1 | busy0 | wr | rd;
        end
        chk("t6_no_done_after_rst", seen, 0);
        rd1 = 1; adr1 = 7'h4C; rd_bytes1 = 3'd4;
        tick; no_strobe();
        tick;
        chk("t6_rd", rd, 1);
        chk("t6_adr", adr, 7'h4C);
        chk("t6_rd_bytes", rd_bytes, 3'd4);
        serve(2, 32'h12345678);
        chk("t6_done1", {done1, err1}, 2'b10);
        chk("t6_rd_data1", rd_data1, 32'h12345678);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
